vga_timing: RTL and testbench

Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync generator. Derives a pixel clock-enable from the system clock by an integer divider, runs horizontal/vertical counters over fully configurable active/porch/sync intervals, and produces registered sync, blank, coordinate and frame/line markers. Sits between the board clock and the pixel source (framebuffer reader, pattern generator) in the video path.

---
 rtl/vga_timing_if.sv | 43 ++++
 rtl/vga_timing.sv | 177 +++++++++++++++++
 tb/tb_vga_timing.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle driven by vga_timing.
// Fetch lookahead signals exist only when VGA_TIMING_FETCH_EN is defined.
//
// Strobe semantics: there is no backpressure. pix_ce is a one-CLK qualifier
// marking the last CLK of each pixel period. x/y/blank/HS/VS are stable for
// the whole pixel period and change on the CLK edge that ends a pix_ce CLK.
// line_start/frame_start are high for the first CLK of a line/frame only.
// x/y are raw counters and must be qualified with blank by the consumer.
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          pix_ce;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          blank;
  logic          HS;
  logic          VS;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FETCH_EN
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;
  logic          fetch_active;
`endif

`ifdef VGA_TIMING_FETCH_EN
  modport master (
    output pix_ce, x, y, blank, HS, VS, line_start, frame_start,
    output fetch_x, fetch_y, fetch_active
  );
  modport slave (
    input pix_ce, x, y, blank, HS, VS, line_start, frame_start,
    input fetch_x, fetch_y, fetch_active
  );
`else
  modport master (
    output pix_ce, x, y, blank, HS, VS, line_start, frame_start
  );
  modport slave (
    input pix_ce, x, y, blank, HS, VS, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// vga_timing: parametrised VGA raster timing generator.
// A CLK divider produces the pixel strobe; horizontal/vertical counters walk
// active, front porch, sync and back porch intervals. Sync/blank outputs are
// registered from the counters' next-state values so they always match the
// current (hc, vc) exactly.
// Optional feature macro: VGA_TIMING_FETCH_EN adds a lookahead position
// counter running FETCH_LEAD pixels ahead of (hc, vc).
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int PIX_DIV    = 2,
  parameter int CW         = 10,
  parameter int FETCH_LEAD = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  vga_timing_if.master o_vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DC_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] HC_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VC_LAST = CW'(V_TOTAL - 1);

  // True when v lies in the half-open interval [lo, hi).
  function automatic logic f_in_range(input logic [CW-1:0] v,
                                      input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  // Advance a (col, row) raster position by one pixel with line/frame wrap.
  function automatic logic [2*CW-1:0] f_step(input logic [CW-1:0] col,
                                             input logic [CW-1:0] row);
    logic [CW-1:0] n_col;
    logic [CW-1:0] n_row;
    n_col = col + 1'b1;
    n_row = row;
    if (col == HC_LAST) begin
      n_col = '0;
      n_row = (row == VC_LAST) ? '0 : row + 1'b1;
    end
    return {n_row, n_col};
  endfunction

  // Divider and raster counters
  logic [DW-1:0] r_dc;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;

  // Registered decodes
  logic          r_pix_ce;
  logic          r_blank;
  logic          r_hs;
  logic          r_vs;

  // Next-state values
  logic          w_dc_last;
  logic [DW-1:0] w_dc_nxt;
  logic [CW-1:0] w_hc_nxt;
  logic [CW-1:0] w_vc_nxt;
  logic          w_line_start;
  logic          w_frame_start;

  assign w_dc_last = (r_dc == DC_LAST);

  // Next-state of divider and raster counters; counters only move on the
  // last CLK of a pixel period.
  always_comb begin
    w_dc_nxt = w_dc_last ? '0 : r_dc + 1'b1;
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (w_dc_last) begin
      {w_vc_nxt, w_hc_nxt} = f_step(r_hc, r_vc);
    end
  end

  // Counter state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dc <= '0;
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_dc <= w_dc_nxt;
      r_hc <= w_hc_nxt;
      r_vc <= w_vc_nxt;
    end
  end

  // Sync/blank/strobe registers decoded from next-state counters so they line
  // up with the counters on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pix_ce <= (PIX_DIV == 1);
      r_blank  <= 1'b0;
      r_hs     <= ~H_POL;
      r_vs     <= ~V_POL;
    end else begin
      r_pix_ce <= (w_dc_nxt == DC_LAST);
      r_blank  <= !f_in_range(w_hc_nxt, 0, H_ACTIVE) ||
                  !f_in_range(w_vc_nxt, 0, V_ACTIVE);
      r_hs     <= f_in_range(w_hc_nxt, HS_START, HS_END) ? H_POL : ~H_POL;
      r_vs     <= f_in_range(w_vc_nxt, VS_START, VS_END) ? V_POL : ~V_POL;
    end
  end

  // Line/frame markers flag the first CLK of (hc == 0). They are gated by
  // RST_N so they read 0 throughout reset yet fire on the very first CLK
  // after release, when the counters already sit at (0, 0).
  assign w_line_start  = RST_N && (r_dc == '0) && (r_hc == '0);
  assign w_frame_start = w_line_start && (r_vc == '0);

  assign o_vga.pix_ce      = r_pix_ce;
  assign o_vga.x           = r_hc;
  assign o_vga.y           = r_vc;
  assign o_vga.blank       = r_blank;
  assign o_vga.HS          = r_hs;
  assign o_vga.VS          = r_vs;
  assign o_vga.line_start  = w_line_start;
  assign o_vga.frame_start = w_frame_start;

`ifdef VGA_TIMING_FETCH_EN
  // Lookahead starts FETCH_LEAD pixels into the first line and then moves in
  // lockstep with (hc, vc), so the offset holds across line and frame wraps.
  localparam logic [CW-1:0] FX_RST = CW'(FETCH_LEAD);
  localparam logic          FA_RST = (FETCH_LEAD < H_ACTIVE) && (V_ACTIVE > 0);

  logic [CW-1:0] r_fx;
  logic [CW-1:0] r_fy;
  logic          r_fa;
  logic [CW-1:0] w_fx_nxt;
  logic [CW-1:0] w_fy_nxt;

  // Next-state of the lookahead position.
  always_comb begin
    w_fx_nxt = r_fx;
    w_fy_nxt = r_fy;
    if (w_dc_last) begin
      {w_fy_nxt, w_fx_nxt} = f_step(r_fx, r_fy);
    end
  end

  // Lookahead position and its active-area flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fx <= FX_RST;
      r_fy <= '0;
      r_fa <= FA_RST;
    end else begin
      r_fx <= w_fx_nxt;
      r_fy <= w_fy_nxt;
      r_fa <= f_in_range(w_fx_nxt, 0, H_ACTIVE) &&
              f_in_range(w_fy_nxt, 0, V_ACTIVE);
    end
  end

  assign o_vga.fetch_x      = r_fx;
  assign o_vga.fetch_y      = r_fy;
  assign o_vga.fetch_active = r_fa;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: bench for vga_timing with three configurations sharing one
// clock and reset: a reduced raster with PIX_DIV=3 and mixed polarity, the
// small PIX_DIV=1 active-high raster, and the default 640x480 timing.
// Expected outputs come from the elapsed CLK count since reset release.
// Honours VGA_TIMING_FETCH_EN when defined.
`timescale 1ns/1ps
module tb_vga_timing;

  typedef struct packed {
    int pd;
    int ha;  int hfp; int hsy; int hbp;
    int va;  int vfp; int vsy; int vbp;
    int lead;
    bit hpol; bit vpol;
  } cfg_t;

  typedef struct packed {
    bit pix_ce;
    int x;  int y;
    bit blank; bit hs; bit vs; bit ls; bit fs;
    int fx; int fy;
    bit fa;
  } exp_t;

  localparam cfg_t CFG_A = '{pd:3, ha:16, hfp:2, hsy:3, hbp:3,
                             va:6, vfp:1, vsy:2, vbp:1, lead:5,
                             hpol:1'b0, vpol:1'b1};
  localparam cfg_t CFG_B = '{pd:1, ha:8, hfp:2, hsy:2, hbp:2,
                             va:4, vfp:1, vsy:1, vbp:1, lead:2,
                             hpol:1'b1, vpol:1'b1};
  localparam cfg_t CFG_C = '{pd:2, ha:640, hfp:16, hsy:96, hbp:48,
                             va:480, vfp:10, vsy:2, vbp:33, lead:2,
                             hpol:1'b0, vpol:1'b0};

  localparam int FRAME_A = 24 * 10 * 3;
  localparam int FRAME_B = 14 * 7 * 1;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_N;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  vga_timing_if #(.CW(8))  if_a ();
  vga_timing_if #(.CW(6))  if_b ();
  vga_timing_if #(.CW(10)) if_c ();

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .PIX_DIV(3), .CW(8), .FETCH_LEAD(5)
  ) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .o_vga(if_a)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CW(6), .FETCH_LEAD(2)
  ) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .o_vga(if_b)
  );

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(2), .CW(10), .FETCH_LEAD(2)
  ) u_dut_c (
    .CLK(CLK), .RST_N(RST_N), .o_vga(if_c)
  );

  // ---------------- bookkeeping ----------------
  int n_checks;
  int n_errors;
  int t;
  bit in_rst;
  int fs_prev_a;
  int fs_prev_b;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d rst=%0d)",
               tag, got, exp, t, in_rst);
    end
  endtask

  // ---------------- reference model ----------------
  // Position follows from elapsed CLKs: pixel index = t / PIX_DIV, laid out
  // row-major over an H_TOTAL x V_TOTAL raster that repeats.
  function automatic exp_t model(input cfg_t c, input int tt, input bit rst);
    exp_t e;
    int ht, vt, p, dc, hc, vc, q;
    ht = c.ha + c.hfp + c.hsy + c.hbp;
    vt = c.va + c.vfp + c.vsy + c.vbp;
    if (rst) tt = 0;
    p  = tt / c.pd;
    dc = tt % c.pd;
    hc = p % ht;
    vc = (p / ht) % vt;
    e.pix_ce = (dc == c.pd - 1);
    e.x      = hc;
    e.y      = vc;
    e.blank  = (hc >= c.ha) || (vc >= c.va);
    e.hs     = (hc >= c.ha + c.hfp && hc < c.ha + c.hfp + c.hsy) ? c.hpol : !c.hpol;
    e.vs     = (vc >= c.va + c.vfp && vc < c.va + c.vfp + c.vsy) ? c.vpol : !c.vpol;
    e.ls     = !rst && (dc == 0) && (hc == 0);
    e.fs     = e.ls && (vc == 0);
    q        = p + c.lead;
    e.fx     = q % ht;
    e.fy     = (q / ht) % vt;
    e.fa     = (e.fx < c.ha) && (e.fy < c.va);
    return e;
  endfunction

  task automatic check_set(input string n, input exp_t e,
                           input bit pc, input int x, input int y,
                           input bit bl, input bit hs, input bit vs,
                           input bit ls, input bit fs,
                           input int fx, input int fy, input bit fa);
    check({n, ".pix_ce"},      32'(pc), 32'(e.pix_ce));
    check({n, ".x"},           32'(x),  32'(e.x));
    check({n, ".y"},           32'(y),  32'(e.y));
    check({n, ".blank"},       32'(bl), 32'(e.blank));
    check({n, ".HS"},          32'(hs), 32'(e.hs));
    check({n, ".VS"},          32'(vs), 32'(e.vs));
    check({n, ".line_start"},  32'(ls), 32'(e.ls));
    check({n, ".frame_start"}, 32'(fs), 32'(e.fs));
`ifdef VGA_TIMING_FETCH_EN
    check({n, ".fetch_x"},      32'(fx), 32'(e.fx));
    check({n, ".fetch_y"},      32'(fy), 32'(e.fy));
    check({n, ".fetch_active"}, 32'(fa), 32'(e.fa));
`endif
  endtask

  // Frame-start scoreboard for A plus frame spacing for A and B.
  task automatic score_frames();
    exp_t ea;
    ea = model(CFG_A, t, in_rst);
    if (ea.fs) exp_q.push_back(32'(t));
    if (if_a.frame_start === 1'b1) begin
      if (exp_q.size() == 0) check("A.fs_unexpected", 32'(if_a.frame_start), 32'd0);
      else check("A.fs_time", 32'(t), exp_q.pop_front());
      if (fs_prev_a >= 0) check("A.frame_len", 32'(t - fs_prev_a), 32'(FRAME_A));
      fs_prev_a = t;
    end
    if (if_b.frame_start === 1'b1) begin
      if (fs_prev_b >= 0) check("B.frame_len", 32'(t - fs_prev_b), 32'(FRAME_B));
      fs_prev_b = t;
    end
  endtask

  task automatic check_all();
    int fxa, fya, fxb, fyb, fxc, fyc;
    bit faa, fab, fac;
`ifdef VGA_TIMING_FETCH_EN
    fxa = int'(if_a.fetch_x); fya = int'(if_a.fetch_y); faa = if_a.fetch_active;
    fxb = int'(if_b.fetch_x); fyb = int'(if_b.fetch_y); fab = if_b.fetch_active;
    fxc = int'(if_c.fetch_x); fyc = int'(if_c.fetch_y); fac = if_c.fetch_active;
`else
    fxa = 0; fya = 0; faa = 1'b0;
    fxb = 0; fyb = 0; fab = 1'b0;
    fxc = 0; fyc = 0; fac = 1'b0;
`endif
    check_set("A", model(CFG_A, t, in_rst), if_a.pix_ce, int'(if_a.x), int'(if_a.y),
              if_a.blank, if_a.HS, if_a.VS, if_a.line_start, if_a.frame_start,
              fxa, fya, faa);
    check_set("B", model(CFG_B, t, in_rst), if_b.pix_ce, int'(if_b.x), int'(if_b.y),
              if_b.blank, if_b.HS, if_b.VS, if_b.line_start, if_b.frame_start,
              fxb, fyb, fab);
    check_set("C", model(CFG_C, t, in_rst), if_c.pix_ce, int'(if_c.x), int'(if_c.y),
              if_c.blank, if_c.HS, if_c.VS, if_c.line_start, if_c.frame_start,
              fxc, fyc, fac);
    score_frames();
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; checks each CLK then advances one CLK.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1 check_all();
      @(negedge CLK);
      t++;
    end
  endtask

  // Asserts reset between clock edges so outputs must drop asynchronously,
  // holds it for k CLKs, then releases on a falling edge.
  task automatic reset_pulse(input int k);
    RST_N  = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      #1 check_all();
      @(negedge CLK);
    end
    RST_N     = 1'b1;
    in_rst    = 1'b0;
    t         = 0;
    fs_prev_a = -1;
    fs_prev_b = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    t         = 0;
    fs_prev_a = -1;
    fs_prev_b = -1;
    RST_N     = 1'b0;
    in_rst    = 1'b1;
    @(negedge CLK);
    reset_pulse(10);
    // Long run: several A/B frames and over two default lines.
    run(3500);
    // Random mid-frame resets with random run lengths.
    for (int it = 0; it < 5; it++) begin
      run($urandom_range(1500, 40));
      reset_pulse($urandom_range(4, 1));
    end
    run(FRAME_A + 50);
    check("A.fs_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
